// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for elastic pipeline stages: FSM states, bubble
// control constants and field offsets used to pack inter-stage payloads.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,
    STAGE_BUSY  = 2'd1,
    STAGE_FULL  = 2'd2
  } stage_state_e;

  // MEM/WB payload: {alu_result, read_data, write_register, pc_plus_4}
  localparam int unsigned MEMWB_PC4_LSB    = 0;
  localparam int unsigned MEMWB_WREG_LSB   = 32;
  localparam int unsigned MEMWB_RDATA_LSB  = 37;
  localparam int unsigned MEMWB_ALU_LSB    = 69;
  localparam int unsigned MEMWB_DATA_WIDTH = 101;

  // MEM/WB control: {reg_write, mem_to_reg, is_jal}
  localparam int unsigned MEMWB_CTRL_IS_JAL    = 0;
  localparam int unsigned MEMWB_CTRL_MEM2REG   = 1;
  localparam int unsigned MEMWB_CTRL_REG_WRITE = 2;
  localparam int unsigned MEMWB_CTRL_WIDTH     = 3;
  localparam logic [2:0]  CTRL_BUBBLE_MEMWB    = 3'b000;

  function automatic logic [1:0] level_of(input stage_state_e s);
    case (s)
      STAGE_BUSY: level_of = 2'd1;
      STAGE_FULL: level_of = 2'd2;
      default:    level_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with registered in_ready, 2-entry skid buffer,
// synchronous flush and bubble gating of the control word.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH  = 101,
  parameter int unsigned                CTRL_WIDTH  = 3,
  parameter logic [CTRL_WIDTH-1:0]      CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            level
);

  stage_state_e          state, state_next;
  logic [DATA_WIDTH-1:0] main_data, skid_data;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
  logic                  in_fire;
  logic                  main_load, main_from_skid, skid_load;

  assign in_fire = in_valid & in_ready;

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state)
      STAGE_EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          state_next = STAGE_BUSY;
        end
      end
      STAGE_BUSY: begin
        if (in_fire && out_ready) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          state_next = STAGE_FULL;
        end else if (out_ready) begin
          state_next = STAGE_EMPTY;
        end
      end
      STAGE_FULL: begin
        if (out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = STAGE_BUSY;
        end
      end
      default: state_next = STAGE_EMPTY;
    endcase
    // Flush discards any accept in the same cycle; held data stays but is hidden.
    if (flush) begin
      state_next = STAGE_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STAGE_EMPTY;
      in_ready  <= 1'b1;
      level     <= 2'd0;
      main_data <= '0;
      skid_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
      skid_ctrl <= CTRL_BUBBLE;
    end else begin
      state    <= state_next;
      // in_ready and level are derived from the next state so they stay flops.
      in_ready <= (state_next != STAGE_FULL);
      level    <= level_of(state_next);
      if (main_load) begin
        main_data <= main_from_skid ? skid_data : in_data;
        main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
      end
      if (skid_load) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_valid = (state != STAGE_EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;

endmodule
